// File: rtl/cache_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cache_bus_arbiter
//
// Two-port round-robin arbiter between a pair of cache controllers and a
// single line-wide memory port. One line transaction (read or write-back)
// is in flight at a time. Every write-back broadcasts a one-cycle
// snoop-invalidate so the other cache can drop its stale copy.
//
// Optional feature (compile-time macro): BUS_TIMEOUT_EN
//   When defined, a watchdog counts MEM_WAIT cycles. If mem_ready has not
//   arrived after TIMEOUT_CYCLES cycles, the transaction is completed with
//   bus_error and resp_ready pulsing together. When undefined there is no
//   counter, bus_error is tied low and MEM_WAIT waits indefinitely.
//
// Parameters
//   ADDRESS_BITS   address width
//   WORDSIZE       bits per word
//   WORDSPERLINE   words per cache line (LW = WORDSPERLINE*WORDSIZE)
//   TIMEOUT_CYCLES watchdog limit in MEM_WAIT cycles (BUS_TIMEOUT_EN only)
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   req_re       in   [1:0] per-port line read request
//   req_we       in   [1:0] per-port line write-back request
//   req_addr     in   [1:0] per-port request address
//   req_data     in   [1:0] per-port write-back line
//   granted      out  [1:0] per-port bus grant (one-hot or zero)
//   resp_ready   out  [1:0] one-cycle completion pulse to the granted port
//   resp_data    out  read line returned to the granted port
//   mem_addr     out  line-aligned memory address
//   mem_wdata    out  write line to memory
//   mem_re       out  memory read strobe
//   mem_we       out  memory write strobe
//   mem_rdata    in   memory read line
//   mem_ready    in   memory completion
//   snoop_addr   out  line-aligned write address broadcast
//   snoop_we     out  one-cycle snoop-invalidate pulse
//   bus_error    out  one-cycle timeout flag
// ---------------------------------------------------------------------------
module cache_bus_arbiter #(
    parameter int ADDRESS_BITS   = 32,
    parameter int WORDSIZE       = 32,
    parameter int WORDSPERLINE   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [1:0]                                  req_re,
    input  logic [1:0]                                  req_we,
    input  logic [1:0][ADDRESS_BITS-1:0]                req_addr,
    input  logic [1:0][WORDSPERLINE*WORDSIZE-1:0]       req_data,
    output logic [1:0]                                  granted,
    output logic [1:0]                                  resp_ready,
    output logic [WORDSPERLINE*WORDSIZE-1:0]            resp_data,
    output logic [ADDRESS_BITS-1:0]                     mem_addr,
    output logic [WORDSPERLINE*WORDSIZE-1:0]            mem_wdata,
    output logic                                        mem_re,
    output logic                                        mem_we,
    input  logic [WORDSPERLINE*WORDSIZE-1:0]            mem_rdata,
    input  logic                                        mem_ready,
    output logic [ADDRESS_BITS-1:0]                     snoop_addr,
    output logic                                        snoop_we,
    output logic                                        bus_error
);

    localparam int LW          = WORDSPERLINE * WORDSIZE;
    localparam int OFFSET_BITS = $clog2(LW / 8);
    // Clears the byte-offset-within-line bits of an address.
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK =
        ~((ADDRESS_BITS'(1) << OFFSET_BITS) - ADDRESS_BITS'(1));

    // Elaboration-time sanity checks on the configuration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cache_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end
    if (LW < 8) begin : g_bad_line
        $error("cache_bus_arbiter: a line must be at least one byte wide");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    rr_q;        // round-robin pointer: preferred port
    logic                    port_q;      // port that owns the current transaction
    logic                    is_write_q;  // latched operation of the current transaction
    logic [1:0]              granted_q;
    logic [1:0]              resp_ready_q;
    logic [LW-1:0]           resp_data_q;
    logic [ADDRESS_BITS-1:0] mem_addr_q;
    logic [LW-1:0]           mem_wdata_q;
    logic                    mem_re_q;
    logic                    mem_we_q;
    logic [ADDRESS_BITS-1:0] snoop_addr_q;
    logic                    snoop_we_q;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             bus_error_q;
    logic             timeout_hit;
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Selection: the pointed-to port wins if it requests, otherwise the
    // other port (which must then be the only requester).
    logic [1:0]              req_any;
    logic                    sel_port;
    logic                    sel_write;
    logic [ADDRESS_BITS-1:0] sel_addr;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_any   = req_re | req_we;
        sel_port  = req_any[rr_q] ? rr_q : ~rr_q;
        // A simultaneous read and write-back from one port is a write.
        sel_write = req_we[sel_port];
        sel_addr  = req_addr[sel_port] & ALIGN_MASK;
    end

    // NOTE: state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            port_q       <= 1'b0;
            is_write_q   <= 1'b0;
            granted_q    <= '0;
            resp_ready_q <= '0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            snoop_addr_q <= '0;
            snoop_we_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q   <= '0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    resp_ready_q <= '0;
                    if (|req_any) begin
                        state_q     <= MEM_WAIT;
                        port_q      <= sel_port;
                        is_write_q  <= sel_write;
                        granted_q   <= 2'b01 << sel_port;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= req_data[sel_port];
                        mem_re_q    <= ~sel_write;
                        mem_we_q    <= sel_write;
                        // Invalidate broadcast coincides with the first
                        // MEM_WAIT cycle of a write only.
                        snoop_we_q  <= sel_write;
                        if (sel_write) begin
                            snoop_addr_q <= sel_addr;
                        end
`ifdef BUS_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                    end
                end

                MEM_WAIT: begin
                    snoop_we_q <= 1'b0;
                    if (mem_ready) begin
                        state_q      <= RESP;
                        mem_re_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_ready_q <= granted_q;
                        if (!is_write_q) begin
                            resp_data_q <= mem_rdata;
                        end
`ifdef BUS_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        // Give up on memory: complete with an error and keep
                        // the previous resp_data.
                        state_q      <= RESP;
                        mem_re_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_ready_q <= granted_q;
                        bus_error_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end

                RESP: begin
                    state_q      <= IDLE;
                    granted_q    <= '0;
                    resp_ready_q <= '0;
                    rr_q         <= ~port_q;
`ifdef BUS_TIMEOUT_EN
                    bus_error_q  <= 1'b0;
`endif
                end

                default: begin
                    state_q      <= IDLE;
                    granted_q    <= '0;
                    resp_ready_q <= '0;
                    mem_re_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    snoop_we_q   <= 1'b0;
                end
            endcase
        end
    end

    assign granted    = granted_q;
    assign resp_ready = resp_ready_q;
    assign resp_data  = resp_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign snoop_addr = snoop_addr_q;
    assign snoop_we   = snoop_we_q;
`ifdef BUS_TIMEOUT_EN
    assign bus_error  = bus_error_q;
`else
    assign bus_error  = 1'b0;
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_bus_arbiter
//
// Directed self-checking bench for cache_bus_arbiter with default widths
// (32-bit address, 64-bit line) and TIMEOUT_CYCLES = 4. Inputs are driven
// and outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_cache_bus_arbiter;

    localparam int AW = 32;
    localparam int LW = 64;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [1:0]           req_re;
    logic [1:0]           req_we;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][LW-1:0]   req_data;
    logic [1:0]           granted;
    logic [1:0]           resp_ready;
    logic [LW-1:0]        resp_data;
    logic [AW-1:0]        mem_addr;
    logic [LW-1:0]        mem_wdata;
    logic                 mem_re;
    logic                 mem_we;
    logic [LW-1:0]        mem_rdata;
    logic                 mem_ready;
    logic [AW-1:0]        snoop_addr;
    logic                 snoop_we;
    logic                 bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    cache_bus_arbiter #(
        .ADDRESS_BITS  (AW),
        .WORDSIZE      (32),
        .WORDSPERLINE  (2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_re     (req_re),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .granted    (granted),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .snoop_addr (snoop_addr),
        .snoop_we   (snoop_we),
        .bus_error  (bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    localparam logic [63:0] LINE_A = {32'h00000023, 32'h00000013};
    localparam logic [63:0] LINE_B = {32'h70000083, 32'hEF000013};
    localparam logic [63:0] LINE_C = 64'h1111_2222_3333_4444;

    initial begin
        reset     = 1'b1;
        req_re    = '0;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_granted",    64'(granted),    64'h0);
        check("rst_resp_ready", 64'(resp_ready), 64'h0);
        check("rst_mem_strobe", 64'({mem_re, mem_we}), 64'h0);
        check("rst_snoop_we",   64'(snoop_we),   64'h0);
        check("rst_bus_error",  64'(bus_error),  64'h0);
        check("rst_mem_addr",   64'(mem_addr),   64'h0);
        check("rst_resp_data",  resp_data,       64'h0);
        reset = 1'b0;

        // Port 0 line read, one-cycle memory
        req_re      = 2'b01;
        req_addr[0] = 32'h00000001;
        tick();
        check("rd_granted",  64'(granted),  64'h1);
        check("rd_mem_re",   64'(mem_re),   64'h1);
        check("rd_mem_we",   64'(mem_we),   64'h0);
        check("rd_mem_addr", 64'(mem_addr), 64'h0);
        check("rd_snoop_we", 64'(snoop_we), 64'h0);
        req_re    = '0;   // dropping the request must not abort
        mem_ready = 1'b1;
        mem_rdata = LINE_A;
        tick();
        check("rd_resp_ready",  64'(resp_ready), 64'h1);
        check("rd_resp_data",   resp_data,       LINE_A);
        check("rd_granted_rsp", 64'(granted),    64'h1);
        check("rd_mem_re_rsp",  64'(mem_re),     64'h0);
        check("rd_snoop_rsp",   64'(snoop_we),   64'h0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        check("rd_idle_granted", 64'(granted),    64'h0);
        check("rd_idle_resp",    64'(resp_ready), 64'h0);

        // Port 1 write-back with a one-cycle wait state
        req_we      = 2'b10;
        req_addr[1] = 32'h0000000C;
        req_data[1] = LINE_B;
        tick();
        check("wr_granted",    64'(granted),    64'h2);
        check("wr_mem_we",     64'(mem_we),     64'h1);
        check("wr_mem_re",     64'(mem_re),     64'h0);
        check("wr_mem_addr",   64'(mem_addr),   64'h8);
        check("wr_mem_wdata",  mem_wdata,       LINE_B);
        check("wr_snoop_we",   64'(snoop_we),   64'h1);
        check("wr_snoop_addr", 64'(snoop_addr), 64'h8);
        req_we = '0;
        tick();
        check("wr_snoop_once", 64'(snoop_we), 64'h0);
        check("wr_mem_we_hold", 64'(mem_we),  64'h1);
        check("wr_addr_hold",  64'(mem_addr), 64'h8);
        mem_ready = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;   // must not be captured on a write
        tick();
        check("wr_resp_ready", 64'(resp_ready), 64'h2);
        check("wr_resp_data",  resp_data,       LINE_A);
        mem_ready = 1'b0;
        tick();
        check("wr_idle_granted", 64'(granted), 64'h0);

        // Both ports requesting continuously; port 0 asserts re and we (a
        // write), mem_ready held high including outside MEM_WAIT.
        req_re      = 2'b11;
        req_we      = 2'b01;
        req_addr[0] = 32'h00000104;
        req_addr[1] = 32'h0000020F;
        mem_ready   = 1'b1;
        mem_rdata   = LINE_C;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            check($sformatf("rr%0d_granted", i), 64'(granted),  64'(exp_g));
            check($sformatf("rr%0d_mem_we", i),  64'(mem_we),   64'(exp_g == 2'b01));
            check($sformatf("rr%0d_snoop", i),   64'(snoop_we), 64'(exp_g == 2'b01));
            check($sformatf("rr%0d_addr", i),    64'(mem_addr),
                  (exp_g == 2'b01) ? 64'h100 : 64'h208);
            tick();
            check($sformatf("rr%0d_resp", i),    64'(resp_ready), 64'(exp_g));
            tick();
            check($sformatf("rr%0d_idle", i),    64'({granted, resp_ready}), 64'h0);
        end

        // Reset two cycles into MEM_WAIT; pointer was left at port 1
        req_re    = 2'b10;
        req_we    = '0;
        mem_ready = 1'b0;
        tick();
        check("rst_mid_granted", 64'(granted), 64'h2);
        req_re = '0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_granted0",  64'(granted),    64'h0);
        check("rst_mid_resp",      64'(resp_ready), 64'h0);
        check("rst_mid_strobes",   64'({mem_re, mem_we, snoop_we}), 64'h0);
        check("rst_mid_mem_addr",  64'(mem_addr),   64'h0);
        check("rst_mid_wdata",     mem_wdata,       64'h0);
        check("rst_mid_snoop_adr", 64'(snoop_addr), 64'h0);
        check("rst_mid_resp_data", resp_data,       64'h0);
        reset  = 1'b0;
        req_re = 2'b11;
        tick();
        check("rst_next_grant", 64'(granted), 64'h1);
        req_re    = '0;
        mem_ready = 1'b1;
        tick();
        check("rst_next_resp", resp_data, LINE_C);
        mem_ready = 1'b0;
        tick();

        // Memory never answers
        req_re    = 2'b10;
        mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        check("to_granted", 64'(granted), 64'h2);
        req_re = '0;
`ifdef BUS_TIMEOUT_EN
        tick();
        tick();
        tick();
        check("to_before_err",  64'({bus_error, resp_ready}), 64'h0);
        tick();
        check("to_bus_error",   64'(bus_error),  64'h1);
        check("to_resp_ready",  64'(resp_ready), 64'h2);
        check("to_resp_data",   resp_data,       LINE_C);
        tick();
        check("to_idle",        64'({bus_error, granted, resp_ready}), 64'h0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("hang_granted",   64'(granted),    64'h2);
        check("hang_mem_re",    64'(mem_re),     64'h1);
        check("hang_bus_error", 64'(bus_error),  64'h0);
        check("hang_resp",      64'(resp_ready), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL use parameter ADDRESS_BITS, default 32, address width.
REQ-002 SHALL use parameter WORDSIZE, default 32, bits per word.
REQ-003 SHALL use parameter WORDSPERLINE, default 2, words per cache line (LW = WORDSPERLINE*WORDSIZE).
REQ-004 SHALL use parameter TIMEOUT_CYCLES, default 64, memory watchdog limit.
REQ-005 SHALL have the ports below, one per line:
  clock  in  1  single clock; all logic on its rising edge
  reset  in  1  synchronous, active-high reset
  req_re[1:0]  in  2  per-port line read request (port0, port1)
  req_we[1:0]  in  2  per-port line write-back request
  req_addr[1:0]  in  2xADDRESS_BITS  per-port request address
  req_data[1:0]  in  2xLW  per-port write-back line
  granted[1:0]  out  2  per-port bus grant
  resp_ready[1:0]  out  2  one-cycle completion pulse per port
  resp_data  out  LW  read line returned to granted port
  mem_addr  out  ADDRESS_BITS  line-aligned memory address
  mem_wdata  out  LW  write line to memory
  mem_re / mem_we  out  1 / 1  memory read / write strobes
  mem_rdata  in  LW  memory read line
  mem_ready  in  1  memory completion
  snoop_addr  out  ADDRESS_BITS  line-aligned write address broadcast
  snoop_we  out  1  one-cycle snoop-invalidate pulse
  bus_error  out  1  timeout flag, one cycle

Function
REQ-006 SHALL implement FSM states IDLE, MEM_WAIT, RESP.
REQ-007 In IDLE with any req_re|req_we asserted, SHALL choose one port by round-robin pointer rr (requesting port rr wins; otherwise the only requester), latch its op/address/data, move to MEM_WAIT.
REQ-008 SHALL assert granted[p] and mem_re or mem_we from the cycle after selection until the RESP cycle inclusive; mem strobes only in MEM_WAIT.
REQ-009 If req_we and req_re are both high for the chosen port, SHALL treat the transaction as a write.
REQ-010 mem_addr and snoop_addr SHALL equal the latched address with the low log2(LW/8) bits cleared.
REQ-011 On entry to MEM_WAIT for a write, SHALL pulse snoop_we for exactly one cycle; snoop_we SHALL never assert for reads.
REQ-012 In MEM_WAIT, SHALL hold all mem outputs stable until mem_ready=1, then capture mem_rdata (reads) and go to RESP.
REQ-013 In RESP, SHALL pulse resp_ready[p] one cycle with resp_data valid (reads; writes drive the last captured value), set rr to the other port, return to IDLE.
REQ-014 Minimum latency: request seen cycle 0, mem_re cycle 1, mem_ready cycle 1, resp_ready cycle 2; next grant earliest cycle 3.
REQ-015 Requests dropped after selection SHALL NOT abort the transaction; requests arriving outside IDLE SHALL wait.
REQ-016 granted SHALL be one-hot or zero at all times; resp_ready only to the granted port.
REQ-017 mem_ready outside MEM_WAIT SHALL be ignored.

Reset
REQ-018 On reset: state IDLE, rr=0, granted=0, resp_ready=0, mem_re=mem_we=0, snoop_we=0, bus_error=0, mem_addr/mem_wdata/resp_data/snoop_addr=0.
REQ-019 Reset mid-transaction SHALL abandon it at the next edge with no resp_ready pulse.

Configuration
REQ-020 With BUS_TIMEOUT_EN defined, SHALL count MEM_WAIT cycles; at TIMEOUT_CYCLES without mem_ready, SHALL pulse bus_error and resp_ready[p] together, go through RESP to IDLE, resp_data unchanged.
REQ-021 Without BUS_TIMEOUT_EN, no counter SHALL exist, bus_error tied 0, MEM_WAIT waits indefinitely.

Verification
REQ-022 Port0 req_re addr 0x00000001, mem_ready one cycle later with rdata {0x00000023,0x00000013} -> mem_addr 0x00000000, resp_ready[0] with that line, snoop_we never high.
REQ-023 Port1 req_we addr 0x0000000C data {0x70000083,0xEF000013} -> mem_we, mem_addr 0x00000008, single snoop_we pulse with snoop_addr 0x00000008, resp_ready[1].
REQ-024 Both ports request in the same cycle, held continuously -> grants alternate 0,1,0,1; never both granted.
REQ-025 reset asserted two cycles into MEM_WAIT -> all outputs zero next edge, no resp_ready, next grant to port 0.
REQ-026 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 -> bus_error and resp_ready[p] pulse after 4 MEM_WAIT cycles; without macro granted stays high.
